// File: rtl/qs_accel_sequencer.sv
// qs_accel_sequencer: control-side initiator for the quicksort pipeline
// accelerator. Walks a run of words in local memory, streams each word onto
// the accelerator (ldMax for the first, compareMax for the rest), waits out
// the adder pipeline, issues getMax and captures minOut as the run result.
//
// Ports
//   clk, rst           sole clock (rising edge), async active-high reset
//   start, base, len   run request; base/len sampled with start in IDLE
//   busy, done, result run status; result holds until the next done
//   mem_rd, mem_addr   buffer read strobe/address; mem_rdata valid 1 cycle later
//   ldMax, compareMax, getMax, dataIn   accelerator control/data
//   minOut             accelerator result, valid ACC_LAT cycles after getMax
//   abort              (only with QS_SEQ_ABORT_EN) drops any run back to IDLE
//
// Build option: define QS_SEQ_ABORT_EN to add the abort input.
module qs_accel_sequencer #(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned ACC_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
`ifdef QS_SEQ_ABORT_EN
  input  logic              abort,
`endif
  output logic              busy,
  output logic              done,
  output logic [31:0]       result,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              ldMax,
  output logic              compareMax,
  output logic              getMax,
  output logic [31:0]       dataIn,
  input  logic [31:0]       minOut
);

  localparam int unsigned REM_W = ADDR_W + 1;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(ACC_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_DRAIN, S_GET, S_CAPTURE, S_DONE
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  ptr;
  logic [REM_W-1:0]   remain;
  logic               first;
  logic [CNT_W-1:0]   cnt;
  logic               abort_req;

  // Abort only has meaning while a run is in flight.
`ifdef QS_SEQ_ABORT_EN
  assign abort_req = abort && (state != S_IDLE);
`else
  assign abort_req = 1'b0;
`endif

  // Sequencer FSM; all outputs are registered. Read strobes are raised on the
  // transition into FETCH so the read data lands while the FSM sits in ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      ptr        <= '0;
      remain     <= '0;
      first      <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      ldMax      <= 1'b0;
      compareMax <= 1'b0;
      getMax     <= 1'b0;
      dataIn     <= '0;
    end else begin
      // Single-cycle pulses default low every cycle.
      done       <= 1'b0;
      mem_rd     <= 1'b0;
      ldMax      <= 1'b0;
      compareMax <= 1'b0;
      getMax     <= 1'b0;

      if (abort_req) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              busy <= 1'b1;
              if (len == '0) begin
                result <= '0;
                state  <= S_DONE;
              end else begin
                ptr      <= base;
                remain   <= len;
                first    <= 1'b1;
                mem_rd   <= 1'b1;
                mem_addr <= base;
                state    <= S_FETCH;
              end
            end
          end

          S_FETCH: begin
            state <= S_ISSUE;
          end

          // Present the word and exactly one strobe; pointer wraps naturally.
          S_ISSUE: begin
            dataIn     <= mem_rdata;
            ldMax      <= first;
            compareMax <= !first;
            first      <= 1'b0;
            ptr        <= ptr + ADDR_W'(1);
            remain     <= remain - REM_W'(1);
            if (remain == REM_W'(1)) begin
              cnt   <= LAT_M1;
              state <= S_DRAIN;
            end else begin
              mem_rd   <= 1'b1;
              mem_addr <= ptr + ADDR_W'(1);
              state    <= S_FETCH;
            end
          end

          // Let the last compare flush through the adder pipeline.
          S_DRAIN: begin
            if (cnt == '0) begin
              state <= S_GET;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end

          S_GET: begin
            getMax <= 1'b1;
            cnt    <= LAT_M1;
            state  <= S_CAPTURE;
          end

          S_CAPTURE: begin
            if (cnt == '0) begin
              result <= minOut;
              state  <= S_DONE;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end

          S_DONE: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end

          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qs_accel_sequencer.sv
// Self-checking bench for qs_accel_sequencer (ADDR_W=4, ACC_LAT=4).
// A behavioural buffer and a min-tracking accelerator model surround the DUT;
// expected addresses, strobes/data and results are queued per run and
// checked by a negedge monitor as the DUT produces them.
module tb_qs_accel_sequencer;

  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned ACC_LAT = 4;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W:0]   len;
`ifdef QS_SEQ_ABORT_EN
  logic              abort;
`endif
  logic              busy;
  logic              done;
  logic [31:0]       result;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              ldMax;
  logic              compareMax;
  logic              getMax;
  logic [31:0]       dataIn;
  logic [31:0]       minOut;

  qs_accel_sequencer #(.ADDR_W(ADDR_W), .ACC_LAT(ACC_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base       (base),
    .len        (len),
`ifdef QS_SEQ_ABORT_EN
    .abort      (abort),
`endif
    .busy       (busy),
    .done       (done),
    .result     (result),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .ldMax      (ldMax),
    .compareMax (compareMax),
    .getMax     (getMax),
    .dataIn     (dataIn),
    .minOut     (minOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Buffer model: registered read, data valid the cycle after mem_rd.
  logic [31:0] mem [16];
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  // IEEE-754 single "a < b" for finite, non-NaN values.
  function automatic logic flt_lt(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31]) return a[31];
    if (!a[31]) return a[30:0] < b[30:0];
    return a[30:0] > b[30:0];
  endfunction

  // Accelerator model: tracks the minimum; minOut is garbage until getMax.
  logic [31:0] acc;
  logic        got;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      got <= 1'b0;
    end else begin
      if (ldMax) begin
        acc <= dataIn;
        got <= 1'b0;
      end else if (compareMax && flt_lt(dataIn, acc)) begin
        acc <= dataIn;
      end
      if (getMax) got <= 1'b1;
    end
  end
  assign minOut = got ? acc : 32'hFFFF_FFFF;

  // Scoreboard queues.
  typedef struct {
    logic        ld;
    logic [31:0] data;
  } str_t;

  logic [ADDR_W-1:0] addr_q [$];
  str_t              str_q  [$];
  logic [31:0]       res_q  [$];
  int                gm_cnt;

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_rd) begin
        chk("rd_expected", 32'(addr_q.size() != 0), 32'd1);
        if (addr_q.size() != 0) chk("mem_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
      end
      if (ldMax || compareMax) begin
        str_t e;
        chk("one_strobe", 32'(ldMax & compareMax), 32'd0);
        chk("strobe_expected", 32'(str_q.size() != 0), 32'd1);
        if (str_q.size() != 0) begin
          e = str_q.pop_front();
          chk("strobe_kind_ld", 32'(ldMax), 32'(e.ld));
          chk("dataIn", dataIn, e.data);
        end
      end
      if (getMax) gm_cnt++;
      if (done) begin
        chk("done_expected", 32'(res_q.size() != 0), 32'd1);
        if (res_q.size() != 0) chk("result", result, res_q.pop_front());
      end
    end
  end

  typedef struct {
    logic [ADDR_W-1:0] b;
    logic [ADDR_W:0]   l;
    int                lat;
    logic [31:0]       res;
  } vec_t;

  vec_t vecs [7];

  task automatic push_run(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] l);
    for (int k = 0; k < int'(l); k++) begin
      logic [ADDR_W-1:0] a;
      str_t s;
      a = b + ADDR_W'(k);
      addr_q.push_back(a);
      s.ld   = (k == 0);
      s.data = mem[a];
      str_q.push_back(s);
    end
  endtask

  // Drive one run, measure start-to-done latency; optional spurious start.
  task automatic run_vec(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] l,
                         input int lat, input logic [31:0] r, input int spur_at);
    int cyc;
    push_run(b, l);
    res_q.push_back(r);
    gm_cnt = 0;
    @(negedge clk);
    start = 1'b1; base = b; len = l;
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    while (!done && cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start = (spur_at != 0) && (cyc == spur_at);
      if (start) begin
        base = '0;
        len  = 5'd16;
      end
    end
    start = 1'b0;
    chk("latency", 32'(cyc), 32'(lat));
    chk("busy_at_done", 32'(busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("getmax_count", 32'(gm_cnt), 32'(l != 0));
    chk("queues_drained", 32'(addr_q.size() + str_q.size() + res_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; base = '0; len = '0; gm_cnt = 0;
`ifdef QS_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    for (int i = 0; i < 16; i++) mem[i] = 32'h4100_0000;  // 8.0
    mem[0]  = 32'h3F00_0000;  // 0.5
    mem[1]  = 32'h4040_0000;  // 3.0
    mem[2]  = 32'h3F80_0000;  // 1.0
    mem[3]  = 32'hC040_0000;  // -3.0
    mem[4]  = 32'h4000_0000;  // 2.0
    mem[9]  = 32'hC120_0000;  // -10.0
    mem[15] = 32'h40A0_0000;  // 5.0

    vecs[0] = '{4'd2,  5'd3,  17, 32'hC040_0000};
    vecs[1] = '{4'd0,  5'd0,  2,  32'h0000_0000};
    vecs[2] = '{4'd15, 5'd3,  17, 32'h3F00_0000};
    vecs[3] = '{4'd0,  5'd16, 43, 32'hC120_0000};
    vecs[4] = '{4'd5,  5'd1,  13, 32'h4100_0000};
    vecs[5] = '{4'd9,  5'd2,  15, 32'hC120_0000};
    vecs[6] = '{4'd14, 5'd4,  19, 32'h3F00_0000};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_dataIn", dataIn, 32'd0);
    chk("rst_strobes", 32'({ldMax, compareMax, getMax}), 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i].b, vecs[i].l, vecs[i].lat, vecs[i].res, 0);

    // start while busy is ignored
    run_vec(4'd2, 5'd3, 17, 32'hC040_0000, 4);

    // asynchronous reset in the middle of a full-buffer run
    push_run(4'd0, 5'd16);
    res_q.push_back(32'hC120_0000);
    @(negedge clk);
    start = 1'b1; base = '0; len = 5'd16;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_result", result, 32'd0);
    chk("arst_mem_addr", 32'(mem_addr), 32'd0);
    chk("arst_dataIn", dataIn, 32'd0);
    chk("arst_pulses", 32'({done, mem_rd, ldMax, compareMax, getMax}), 32'd0);
    addr_q.delete();
    str_q.delete();
    res_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("busy_after_rst", 32'(busy), 32'd0);
    end
    run_vec(4'd2, 5'd3, 17, 32'hC040_0000, 0);

`ifdef QS_SEQ_ABORT_EN
    begin
      int dn;
      push_run(4'd2, 5'd3);
      @(negedge clk);
      start = 1'b1; base = 4'd2; len = 5'd3;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(posedge clk);   // now in DRAIN
      @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      dn = 0;
      for (int i = 0; i < 25; i++) begin
        @(negedge clk);
        if (done) dn++;
      end
      chk("abort_no_done", 32'(dn), 32'd0);
      chk("abort_result_kept", result, 32'hC040_0000);
      chk("abort_queues", 32'(addr_q.size() + str_q.size()), 32'd0);
      run_vec(4'd9, 5'd2, 15, 32'hC120_0000, 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
